// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// owns the shared memory port handshake, counts retired instructions and traps on type O.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [2:0]       instr_type,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_b,
    output logic             alu_src_a,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_O = 3'd6;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    logic w_is_load;
    logic w_is_store;
    logic w_is_jal;
    logic w_is_jalr;
    logic w_is_lui;
    logic w_is_auipc;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (instr_type == T_S);
    assign w_is_jal   = (opcode == OP_JAL);
    assign w_is_jalr  = (opcode == OP_JALR);
    assign w_is_lui   = (opcode == OP_LUI);
    assign w_is_auipc = (opcode == OP_AUIPC);

    assign retired = r_retired;

    // State register; async reset abandons any pending memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Next-state and strobe decode; only ir_we, MEM pc/retire and branch pc_sel see live inputs.
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        alu_src_b    = 1'b0;
        alu_src_a    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;
        trap         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (instr_type == T_O) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_b = (instr_type == T_I) || (instr_type == T_S) ||
                            (instr_type == T_U) || (instr_type == T_J);
                alu_src_a = w_is_auipc || w_is_jal;
                if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else if (instr_type == T_B) begin
                    pc_we    = 1'b1;
                    pc_sel   = br_taken ? 2'd1 : 2'd0;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_is_store;
                if (!mem_ready) begin
                    w_next = S_MEM;
                end else if (w_is_store) begin
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                pc_we    = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                if (w_is_load) begin
                    wb_sel = 2'd1;
                end else if (w_is_jal || w_is_jalr) begin
                    wb_sel = 2'd2;
                end else if (w_is_lui) begin
                    wb_sel = 2'd3;
                end else begin
                    wb_sel = 2'd0;
                end
                if (w_is_jal) begin
                    pc_sel = 2'd1;
                end else if (w_is_jalr) begin
                    pc_sel = 2'd2;
                end else begin
                    pc_sel = 2'd0;
                end
            end
            S_TRAP: begin
                trap   = 1'b1;
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected strobe vectors for each instruction class.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    localparam logic [2:0] T_R = 3'd0;
    localparam logic [2:0] T_I = 3'd1;
    localparam logic [2:0] T_S = 3'd2;
    localparam logic [2:0] T_B = 3'd3;
    localparam logic [2:0] T_U = 3'd4;
    localparam logic [2:0] T_J = 3'd5;
    localparam logic [2:0] T_O = 3'd6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [6:0]       opcode;
    logic [2:0]       instr_type;
    logic             br_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_is_fetch;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             alu_src_b;
    logic             alu_src_a;
    logic             reg_we;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [CNT_W-1:0] retired;
    logic [12:0]      o_vec;

    int n_vec = 0;
    int n_bad = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .instr_type(instr_type), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_is_fetch(mem_is_fetch),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b),
        .alu_src_a(alu_src_a), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
        .retired(retired)
    );

    assign o_vec = {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel,
                    alu_src_b, alu_src_a, reg_we, wb_sel, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] v(input logic req, input logic we, input logic fe,
                                      input logic irw, input logic pcw, input logic [1:0] pcs,
                                      input logic sb, input logic sa, input logic rw,
                                      input logic [1:0] wbs, input logic tr);
        return {req, we, fe, irw, pcw, pcs, sb, sa, rw, wbs, tr};
    endfunction

    // Vectors shared by several scenarios.
    logic [12:0] V_FW, V_FR, V_ZERO, V_EXI;
    initial begin
        V_FW   = v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        V_FR   = v(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        V_ZERO = 13'd0;
        V_EXI  = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    end

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
        opcode = 7'd0; instr_type = T_R;
        #2;
        n_vec++;
        if (o_vec !== V_ZERO || retired !== 4'd0) begin
            n_bad++;
            $display("FAIL reset: got %b ret %0d want %b ret 0", o_vec, retired, V_ZERO);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_addi();
        logic [12:0] ev [5];
        logic        rd [5];
        ev = '{V_FR, V_ZERO, V_EXI,
               v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0), V_FW};
        rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        opcode = 7'b0010011; instr_type = T_I;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); mem_ready = rd[c]; br_taken = 1'b0; start = 1'b0; #1;
            n_vec++;
            if (o_vec !== ev[c]) begin
                n_bad++;
                $display("FAIL addi cyc%0d: got %b want %b", c, o_vec, ev[c]);
            end
        end
        n_vec++;
        if (retired !== 4'd1) begin
            n_bad++; $display("FAIL addi retired: got %0d want 1", retired);
        end
    endtask

    task automatic test_load_waits();
        logic [12:0] ev [11];
        logic        rd [11];
        logic [12:0] vm;
        vm = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        ev = '{V_FW, V_FW, V_FW, V_FR, V_ZERO, V_EXI, vm, vm, vm,
               v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0), V_FW};
        rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'b0000011; instr_type = T_I;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk); mem_ready = rd[c]; #1;
            n_vec++;
            if (o_vec !== ev[c]) begin
                n_bad++;
                $display("FAIL lw cyc%0d: got %b want %b", c, o_vec, ev[c]);
            end
        end
        n_vec++;
        if (retired !== 4'd2) begin
            n_bad++; $display("FAIL lw retired: got %0d want 2", retired);
        end
    endtask

    task automatic test_store();
        logic [12:0] ev [6];
        logic        rd [6];
        ev = '{V_FR, V_ZERO, V_EXI,
               v(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0),
               v(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), V_FW};
        rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0100011; instr_type = T_S;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); mem_ready = rd[c]; #1;
            n_vec++;
            if (o_vec !== ev[c]) begin
                n_bad++;
                $display("FAIL sw cyc%0d: got %b want %b", c, o_vec, ev[c]);
            end
        end
        n_vec++;
        if (retired !== 4'd3) begin
            n_bad++; $display("FAIL sw retired: got %0d want 3", retired);
        end
    endtask

    task automatic test_branch();
        logic [12:0] ev [4];
        logic        rd [4];
        logic [1:0]  ps;
        opcode = 7'b1100011; instr_type = T_B;
        rd = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            ps = (k == 0) ? 2'd1 : 2'd0;
            ev = '{V_FR, V_ZERO,
                   v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ps, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0), V_FW};
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); mem_ready = rd[c]; br_taken = (k == 0); #1;
                n_vec++;
                if (o_vec !== ev[c]) begin
                    n_bad++;
                    $display("FAIL beq%0d cyc%0d: got %b want %b", k, c, o_vec, ev[c]);
                end
            end
            n_vec++;
            if (retired !== 4'(4 + k)) begin
                n_bad++; $display("FAIL beq%0d retired: got %0d want %0d", k, retired, 4 + k);
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_alu_types();
        logic [6:0]  ops [5];
        logic [2:0]  tys [5];
        logic [12:0] exv [5];
        logic [12:0] wbv [5];
        logic [12:0] ev;
        ops = '{7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011};
        tys = '{T_I, T_J, T_U, T_U, T_R};
        exv = '{V_EXI,
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0),
                V_EXI,
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0),
                V_ZERO};
        wbv = '{v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0),
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0),
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0),
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0),
                v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0)};
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i]; instr_type = tys[i];
            for (int c = 0; c < 5; c++) begin
                @(negedge clk); mem_ready = (c < 4); #1;
                ev = (c == 0) ? V_FR : (c == 1) ? V_ZERO : (c == 2) ? exv[i] :
                     (c == 3) ? wbv[i] : V_FW;
                n_vec++;
                if (o_vec !== ev) begin
                    n_bad++;
                    $display("FAIL type%0d cyc%0d: got %b want %b", i, c, o_vec, ev);
                end
            end
            n_vec++;
            if (retired !== 4'(6 + i)) begin
                n_bad++; $display("FAIL type%0d retired: got %0d want %0d", i, retired, 6 + i);
            end
        end
    endtask

    task automatic test_wrap();
        opcode = 7'b0010011; instr_type = T_I;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk); mem_ready = (c < 4); #1;
            end
            n_vec++;
            if (retired !== 4'((11 + i) % 16) || o_vec !== V_FW) begin
                n_bad++;
                $display("FAIL wrap%0d: got ret %0d vec %b want ret %0d vec %b",
                         i, retired, o_vec, (11 + i) % 16, V_FW);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [12:0] vm;
        vm = v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        opcode = 7'b0000011; instr_type = T_I;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); mem_ready = (c == 0); #1;
        end
        n_vec++;
        if (o_vec !== vm) begin
            n_bad++; $display("FAIL midmem pre: got %b want %b", o_vec, vm);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (mem_req !== 1'b0 || o_vec !== V_ZERO || retired !== 4'd0) begin
            n_bad++;
            $display("FAIL midmem rst: got req %b vec %b ret %0d want 0", mem_req, o_vec, retired);
        end
        @(negedge clk); start = 1'b0; mem_ready = 1'b1; rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_vec++;
            if (o_vec !== V_ZERO) begin
                n_bad++; $display("FAIL idle%0d: got %b want %b", c, o_vec, V_ZERO);
            end
        end
    endtask

    task automatic test_trap();
        logic [12:0] vt;
        vt = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        opcode = 7'b1111111; instr_type = T_O; start = 1'b1;
        @(negedge clk); mem_ready = 1'b1; #1;
        n_vec++;
        if (o_vec !== V_FR) begin
            n_bad++; $display("FAIL trap fetch: got %b want %b", o_vec, V_FR);
        end
        @(negedge clk); #1;
        n_vec++;
        if (o_vec !== V_ZERO) begin
            n_bad++; $display("FAIL trap decode: got %b want %b", o_vec, V_ZERO);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); mem_ready = c[0]; #1;
            n_vec++;
            if (o_vec !== vt || retired !== 4'd0) begin
                n_bad++;
                $display("FAIL trap hold%0d: got %b ret %0d want %b ret 0", c, o_vec, retired, vt);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_waits();
        test_store();
        test_branch();
        test_alu_types();
        test_wrap();
        test_reset_mid_mem();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
